pair_adder_rx: RTL and testbench

PAIR_ADDER_RX -- requirements
Module: pair_adder_rx

---
 rtl/pair_adder_rx.sv | 136 +++++++++++++
 tb/tb_pair_adder_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pair_adder_rx.sv
// pair_adder_rx: collects two operands (A then B) from a valid/ready stream and
// presents their unsigned sum and carry on a valid/ready result port.
//
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   in_data/in_valid   - operand stream (A first, then B)
//   in_ready           - operand accepted this cycle
//   flush              - discards a half-received pair
//   out_sum/out_carry  - low WIDTH bits and carry of A+B
//   out_valid          - result is valid
//   out_ready          - consumer accepts result this cycle
//   pair_count         - completed output transfers, modulo 256
module pair_adder_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       pair_count
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               ready_c;
  logic               in_xfer_c;
  logic               out_xfer_c;
  logic [SUM_W-1:0]   add_c;

  // Ready depends only on state, flush, out_ready; reset forces it low.
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      WAIT_A, WAIT_B: ready_c = ~flush;
      HOLD:           ready_c = out_ready & ~flush;
      default:        ready_c = 1'b0;
    endcase
  end

  assign in_ready   = ready_c & ~rst;
  assign in_xfer_c  = in_valid & in_ready;
  assign out_xfer_c = valid_q & out_ready;
  assign add_c      = SUM_W'(a_q) + SUM_W'(in_data);

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    case (state_q)
      WAIT_A: begin
        if (in_xfer_c) begin
          a_d     = in_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (flush) begin
          a_d     = '0;
          state_d = WAIT_A;
        end else if (in_xfer_c) begin
          sum_d   = add_c[WIDTH-1:0];
          carry_d = add_c[WIDTH];
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_xfer_c) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          // An operand accepted alongside the pop starts the next pair.
          if (in_xfer_c) begin
            a_d     = in_data;
            state_d = WAIT_B;
          end else begin
            state_d = WAIT_A;
          end
        end
      end
      default: begin
        state_d = WAIT_A;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset overrides flush and all transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_sum    = sum_q;
  assign out_carry  = carry_q;
  assign out_valid  = valid_q;
  assign pair_count = cnt_q;

endmodule

// File: tb/tb_pair_adder_rx.sv
// tb_pair_adder_rx: vector table plus hand sequences; results are checked
// through a scoreboard queue filled by the driver and drained by a monitor.
module tb_pair_adder_rx;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   pair_count;

  pair_adder_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_sum    (out_sum),
    .out_carry  (out_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pair_count (pair_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         carry;
  } vec_t;

  typedef struct packed {
    logic         carry;
    logic [W-1:0] sum;
  } res_t;

  res_t       exp_q[$];
  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  logic [7:0] exp_cnt  = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: an output transfer happens at the next posedge when sampled here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      res_t r;
      chk("pair_count_before_pop", 32'(pair_count), 32'(exp_cnt));
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {23'd0, out_carry, out_sum}, 32'hFFFF_FFFF);
      end else begin
        r = exp_q.pop_front();
        chk("result", {23'd0, out_carry, out_sum}, {23'd0, r.carry, r.sum});
      end
      exp_cnt = exp_cnt + 8'd1;
    end
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] s, input logic c);
    res_t r;
    send(a);
    send(b);
    r.sum = s; r.carry = c;
    exp_q.push_back(r);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{a:8'h12, b:8'h34, sum:8'h46, carry:1'b0};
    vecs[1] = '{a:8'hFF, b:8'h02, sum:8'h01, carry:1'b1};
    vecs[2] = '{a:8'h00, b:8'h00, sum:8'h00, carry:1'b0};
    vecs[3] = '{a:8'hFF, b:8'hFF, sum:8'hFE, carry:1'b1};
    vecs[4] = '{a:8'h80, b:8'h80, sum:8'h00, carry:1'b1};
    vecs[5] = '{a:8'h7F, b:8'h01, sum:8'h80, carry:1'b0};
    vecs[6] = '{a:8'h01, b:8'hFE, sum:8'hFF, carry:1'b0};
    vecs[7] = '{a:8'hAA, b:8'h55, sum:8'hFF, carry:1'b0};

    rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    chk("rst_pair_count", 32'(pair_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Table vectors, back to back.
    for (int i = 0; i < 8; i++) send_pair(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].carry);
    drain();
    chk("count_after_table", 32'(pair_count), 32'd8);

    // Backpressure: result held five cycles, then pop with A captured same edge.
    out_ready = 1'b0;
    send_pair(8'h20, 8'h30, 8'h50, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", {23'd0, out_carry, out_sum}, 32'h050);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h10;
    @(negedge clk);
    chk("bp_in_ready_pop", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_valid_cleared", 32'(out_valid), 32'd0);
    begin
      res_t r;
      send(8'h05);
      r.sum = 8'h15; r.carry = 1'b0;
      exp_q.push_back(r);
    end
    drain();

    // Flush drops a pending A; 0x55 must never reach a result.
    send(8'h55);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    send_pair(8'h01, 8'h01, 8'h02, 1'b0);
    drain();

    // Flush while holding keeps the result and still allows the pop.
    out_ready = 1'b0;
    send_pair(8'hF0, 8'h20, 8'h10, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    chk("hold_flush_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drain();
    chk("count_before_rst", 32'(pair_count), 32'd12);

    // Reset while holding drops the result without a transfer.
    out_ready = 1'b0;
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(pair_count), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    exp_cnt = 8'd0;

    // 256 random pairs: pair_count wraps back to zero.
    for (int i = 0; i < 256; i++) begin
      logic [W-1:0] a, b;
      logic [W:0]   s;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      s = {1'b0, a} + {1'b0, b};
      send_pair(a, b, s[W-1:0], s[W]);
    end
    drain();
    chk("wrap_count", 32'(pair_count), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
